// File: rtl/alu_result_misr.sv
// Compacts a stream of ALU results into a MISR signature and checks it against a golden value after NUM_SAMPLES captures.
// Latency: signature/count reflect a sample one cycle after its in_valid edge; done/pass register on the final-sample edge.
// Backpressure: none, every in_valid in CAPTURE is taken; optional idle timeout under `define MISR_TIMEOUT_EN.
module alu_result_misr #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] POLY        = WIDTH'(16'h1021),
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(16'hFFFF),
    parameter int               NUM_SAMPLES = 20
`ifdef MISR_TIMEOUT_EN
    ,
    parameter int               TIMEOUT     = 64
`endif
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               in_valid,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic [WIDTH-1:0]                   expected,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [WIDTH-1:0]                   signature,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   count,
    output logic                               timeout
);

    localparam int CW = $clog2(NUM_SAMPLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] sig_q, sig_n, nxt;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             done_q, done_n;
    logic             pass_q, pass_n;

`ifdef MISR_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0]    idle_q, idle_n;
    logic             tmo_q, tmo_n;
`endif

    assign nxt = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ in_data;

    always_comb begin
        state_n = state_q;
        sig_n   = sig_q;
        cnt_n   = cnt_q;
        done_n  = done_q;
        pass_n  = pass_q;
`ifdef MISR_TIMEOUT_EN
        idle_n  = idle_q;
        tmo_n   = tmo_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_CAPTURE;
                    sig_n   = SEED;
                    cnt_n   = '0;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
`ifdef MISR_TIMEOUT_EN
                    idle_n  = '0;
                    tmo_n   = 1'b0;
`endif
                end
            end
            S_CAPTURE: begin
                // start wins over a same-cycle sample: the run restarts cleanly
                if (start) begin
                    sig_n = SEED;
                    cnt_n = '0;
`ifdef MISR_TIMEOUT_EN
                    idle_n = '0;
`endif
                end else if (in_valid) begin
                    sig_n = nxt;
                    cnt_n = cnt_q + 1'b1;
`ifdef MISR_TIMEOUT_EN
                    idle_n = '0;
`endif
                    if (cnt_q == CW'(NUM_SAMPLES - 1)) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        pass_n  = (nxt == expected);
                    end
                end
`ifdef MISR_TIMEOUT_EN
                else if (idle_q == IW'(TIMEOUT - 1)) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    pass_n  = 1'b0;
                    tmo_n   = 1'b1;
                end else begin
                    idle_n = idle_q + 1'b1;
                end
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef MISR_TIMEOUT_EN
            idle_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            sig_q   <= sig_n;
            cnt_q   <= cnt_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
`ifdef MISR_TIMEOUT_EN
            idle_q  <= idle_n;
            tmo_q   <= tmo_n;
`endif
        end
    end

    assign busy      = (state_q == S_CAPTURE);
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign count     = cnt_q;
`ifdef MISR_TIMEOUT_EN
    assign timeout   = tmo_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_misr.sv
// Directed bench for alu_result_misr: scoreboard of expected signature/count per sample, checked one edge later.
module tb_alu_result_misr;

    logic        clk;
    logic        rst_n;
    logic        start, start1;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] expected;

    logic        busy, done, pass, timeout;
    logic [15:0] signature;
    logic [4:0]  count;

    logic        busy1, done1, pass1, timeout1;
    logic [15:0] sig1;
    logic [0:0]  cnt1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] sig;
        logic [4:0]  cnt;
    } sb_t;
    sb_t sbq[$];

    logic [15:0] m_sig;
    logic [4:0]  m_cnt;

    alu_result_misr dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .expected(expected), .busy(busy), .done(done),
        .pass(pass), .signature(signature), .count(count), .timeout(timeout)
    );

    alu_result_misr #(.NUM_SAMPLES(1), .SEED(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid),
        .in_data(in_data), .expected(expected), .busy(busy1), .done(done1),
        .pass(pass1), .signature(sig1), .count(cnt1), .timeout(timeout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [15:0] d, input logic [15:0] e);
        @(negedge clk);
        start    = s;
        in_valid = v;
        in_data  = d;
        expected = e;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic start_run();
        cyc(1'b1, 1'b0, 16'h0, 16'h0);
        m_sig = 16'hFFFF;
        m_cnt = '0;
        chk("start_busy", 32'(busy), 32'(1'b1));
        chk("start_sig", 32'(signature), 32'(16'hFFFF));
        chk("start_cnt", 32'(count), 32'(5'd0));
    endtask

    task automatic sample(input logic [15:0] d, input logic [15:0] e);
        sb_t ent;
        sb_t got;
        m_sig   = misr(m_sig, d);
        m_cnt   = m_cnt + 5'd1;
        ent.sig = m_sig;
        ent.cnt = m_cnt;
        sbq.push_back(ent);
        cyc(1'b0, 1'b1, d, e);
        got = sbq.pop_front();
        chk("sample_sig", 32'(signature), 32'(got.sig));
        chk("sample_cnt", 32'(count), 32'(got.cnt));
    endtask

    task automatic gaps();
        int n;
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) cyc(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        logic [15:0] d;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; in_valid = 1'b0;
        in_data = '0; expected = '0;
        m_sig = 16'hFFFF; m_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_sig", 32'(signature), 32'(16'hFFFF));
        chk("rst_cnt", 32'(count), 32'(5'd0));
        chk("rst_flags", 32'({busy, done, pass, timeout}), 32'(4'b0000));
        rst_n = 1'b1;

        // in_valid in IDLE must be ignored
        cyc(1'b0, 1'b1, 16'hABCD, 16'h0);
        chk("idle_sig", 32'(signature), 32'(16'hFFFF));
        chk("idle_cnt", 32'(count), 32'(5'd0));
        chk("idle_busy", 32'(busy), 32'(1'b0));

        // single zero sample from SEED, then a wrong golden value
        start_run();
        sample(16'h0000, 16'h0000);
        chk("zero_sig_const", 32'(signature), 32'(16'hEFDF));
        for (int i = 1; i < 20; i++) sample(16'(i * 16'h0101), 16'h0000);
        chk("bad_done", 32'(done), 32'(1'b1));
        chk("bad_pass", 32'(pass), 32'(1'b0));
        chk("bad_busy", 32'(busy), 32'(1'b0));

        // 20 random samples with gaps, correct golden value
        start_run();
        for (int i = 0; i < 20; i++) begin
            gaps();
            d = 16'($urandom);
            sample(d, (i == 19) ? misr(m_sig, d) : 16'h0000);
            if (i < 19) chk("run_done_low", 32'(done), 32'(1'b0));
        end
        chk("good_done", 32'(done), 32'(1'b1));
        chk("good_pass", 32'(pass), 32'(1'b1));
        cyc(1'b0, 1'b1, 16'h5A5A, 16'h0);
        chk("donestate_sig", 32'(signature), 32'(m_sig));
        chk("donestate_cnt", 32'(count), 32'(5'd20));
        chk("donestate_done", 32'(done), 32'(1'b1));

        // NUM_SAMPLES=1, SEED=0 instance
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        chk("n1_busy", 32'(busy1), 32'(1'b1));
        cyc(1'b0, 1'b1, 16'h1234, 16'h1234);
        chk("n1_sig", 32'(sig1), 32'(16'h1234));
        chk("n1_done", 32'(done1), 32'(1'b1));
        chk("n1_pass", 32'(pass1), 32'(1'b1));
        chk("n1_cnt", 32'(cnt1), 32'(1'b1));

        // abort after 7 samples, then a fresh full run
        start_run();
        for (int i = 0; i < 7; i++) sample(16'($urandom), 16'h0);
        cyc(1'b1, 1'b0, 16'h0, 16'h0);
        chk("abort_sig", 32'(signature), 32'(16'hFFFF));
        chk("abort_cnt", 32'(count), 32'(5'd0));
        chk("abort_busy", 32'(busy), 32'(1'b1));
        cyc(1'b1, 1'b1, 16'h7777, 16'h0);
        m_sig = 16'hFFFF;
        m_cnt = '0;
        chk("abort_vld_sig", 32'(signature), 32'(16'hFFFF));
        chk("abort_vld_cnt", 32'(count), 32'(5'd0));
        for (int i = 0; i < 20; i++) begin
            d = 16'($urandom);
            sample(d, (i == 19) ? misr(m_sig, d) : 16'h0000);
        end
        chk("rerun_done", 32'(done), 32'(1'b1));
        chk("rerun_pass", 32'(pass), 32'(1'b1));

        // inactivity after 3 samples
        start_run();
        for (int i = 0; i < 3; i++) sample(16'($urandom), 16'h0);
        repeat (63) cyc(1'b0, 1'b0, 16'h0, 16'h0);
        chk("idle63_busy", 32'(busy), 32'(1'b1));
        chk("idle63_done", 32'(done), 32'(1'b0));
        cyc(1'b0, 1'b0, 16'h0, 16'h0);
`ifdef MISR_TIMEOUT_EN
        chk("tmo_done", 32'(done), 32'(1'b1));
        chk("tmo_flag", 32'(timeout), 32'(1'b1));
        chk("tmo_pass", 32'(pass), 32'(1'b0));
`else
        repeat (16) cyc(1'b0, 1'b0, 16'h0, 16'h0);
        chk("notmo_busy", 32'(busy), 32'(1'b1));
        chk("notmo_done", 32'(done), 32'(1'b0));
        chk("notmo_flag", 32'(timeout), 32'(1'b0));
`endif
        chk("tmo_cnt", 32'(count), 32'(5'd3));
        chk("tmo_sig", 32'(signature), 32'(m_sig));

        // asynchronous reset in the middle of a run
        start_run();
        sample(16'h1111, 16'h0);
        sample(16'h2222, 16'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sig", 32'(signature), 32'(16'hFFFF));
        chk("arst_cnt", 32'(count), 32'(5'd0));
        chk("arst_flags", 32'({busy, done, pass}), 32'(3'b000));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 16'h3333, 16'h0);
        chk("arst_idle_sig", 32'(signature), 32'(16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
